issue_queue: RTL and testbench
==============================

ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 SHALL have parameter DISPATCH_WIDTH, default 2, dispatch slots accepted per cycle.
REQ-002 SHALL have parameter ENTRIES, default 8, queue depth; ENTRIES >= DISPATCH_WIDTH.
REQ-003 SHALL have parameter PHYS_REGS_ADDR_WIDTH, default 6, physical register tag width.
REQ-004 SHALL have parameter WB_WIDTH, default 2, number of wakeup broadcast ports.
REQ-005 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port dispatch_en  input  [DISPATCH_WIDTH]  slot i carries a valid instruction.
REQ-008 SHALL have port dispatch_alu_cmd  input  common::alu_cmd_t per slot  ALU command.
REQ-009 SHALL have ports dispatch_op1_valid, dispatch_op2_valid  input  1 per slot  operand already available.
REQ-010 SHALL have port dispatch_op1  input  PHYS_REGS_ADDR_WIDTH per slot  op1 source tag.
REQ-011 SHALL have port dispatch_op2  input  32 per slot  immediate, or source tag in low bits when op2_type is register.
REQ-012 SHALL have port dispatch_op2_type  input  common::op_type_t per slot  register or immediate.
REQ-013 SHALL have port dispatch_phys_rd  input  PHYS_REGS_ADDR_WIDTH per slot  destination tag.
REQ-014 SHALL have port full  output  1  fewer than DISPATCH_WIDTH free entries.
REQ-015 SHALL have ports wb_en  input  [WB_WIDTH], wb_tag  input  PHYS_REGS_ADDR_WIDTH per port  tag-ready broadcast.
REQ-016 SHALL have ports issue_valid  output  1, issue_ready  input  1  issue handshake.
REQ-017 SHALL have ports issue_alu_cmd, issue_op1, issue_op2, issue_op2_type, issue_phys_rd  output  same widths as dispatch  selected entry payload.

Function
REQ-018 Each entry SHALL hold valid, alu_cmd, op1, op1_rdy, op2, op2_rdy, op2_type, phys_rd, and an age counter.
REQ-019 full SHALL be combinational from registered free count: full = (free < DISPATCH_WIDTH).
REQ-020 Dispatch SHALL be ignored entirely (no entry written) in any cycle where full=1.
REQ-021 When full=0, enabled slots SHALL be written in slot order into the lowest-index free entries, valid next cycle.
REQ-022 Entries freed by issue in cycle N SHALL be counted free only from cycle N+1.
REQ-023 Wakeup: any valid entry whose op1 equals an enabled wb_tag SHALL set op1_rdy; op2 likewise only when op2_type is register.
REQ-024 Immediate op2 SHALL be treated as ready regardless of dispatch_op2_valid.
REQ-025 Wakeup SHALL also apply to instructions being dispatched in the same cycle (operand matching wb_tag written as ready).
REQ-026 An entry SHALL be issue-eligible when valid, op1_rdy and op2_rdy are set in registered state; same-cycle wakeup becomes eligible next cycle.
REQ-027 Select SHALL pick the eligible entry with the greatest age; ties broken by lowest index.
REQ-028 Age SHALL be 0 on insertion and increment each cycle the entry remains valid, saturating at its maximum.
REQ-029 issue_valid SHALL be combinational: 1 when any entry is eligible; payload SHALL reflect the selected entry.
REQ-030 On issue_valid && issue_ready the selected entry SHALL be invalidated at the clock edge; otherwise it stays and payload holds.
REQ-031 At most one entry SHALL issue per cycle.

Reset
REQ-032 While rst=1 all entries SHALL be invalid, free count = ENTRIES, full=0, issue_valid=0.
REQ-033 Reset asserted mid-operation SHALL discard all entries immediately, without completing a pending issue or dispatch.

Verification
REQ-034 After reset, dispatch 2 slots both operands ready (op1=5, op2 imm 0x10) -> next cycle issue_valid=1, issue_op1=5, issue_op2=0x10; ready=1 -> entry removed.
REQ-035 Dispatch op1=7 not ready; pulse wb_en[0], wb_tag=7 two cycles later -> issue_valid=1 exactly one cycle after wakeup.
REQ-036 Dispatch op1=9 not ready with wb_tag=9 same cycle -> entry written ready, issue_valid=1 next cycle.
REQ-037 Fill to 7 of 8 entries with issue_ready=0 -> full=1, further dispatch dropped; issue one -> full stays 1 that cycle, clears next cycle.
REQ-038 Two eligible entries, older at index 3, younger at index 0 -> index 3 issued first.
REQ-039 Assert rst with 4 valid entries and issue_ready=1 -> issue_valid=0 and full=0 immediately, no issue handshake completes.

Source files
------------

// File: rtl/issue_queue.sv
// Shared ALU/operand encodings plus the age-ordered issue queue with tag wakeup.
// Select picks the oldest entry whose operands are ready; ties go to the lowest index.
package common;
    typedef enum logic [3:0] {
        AluAdd, AluSub, AluAnd, AluOr, AluXor, AluSll, AluSrl, AluSra, AluSlt, AluSltu
    } alu_cmd_t;

    typedef enum logic {OpReg, OpImm} op_type_t;
endpackage

module issue_queue #(
    parameter int unsigned DISPATCH_WIDTH       = 2,
    parameter int unsigned ENTRIES              = 8,
    parameter int unsigned PHYS_REGS_ADDR_WIDTH = 6,
    parameter int unsigned WB_WIDTH             = 2
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic              [DISPATCH_WIDTH-1:0]                 dispatch_en,
    input  common::alu_cmd_t  [DISPATCH_WIDTH-1:0]                 dispatch_alu_cmd,
    input  logic              [DISPATCH_WIDTH-1:0]                 dispatch_op1_valid,
    input  logic              [DISPATCH_WIDTH-1:0]                 dispatch_op2_valid,
    input  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0]    dispatch_op1,
    input  logic [DISPATCH_WIDTH-1:0][31:0]                        dispatch_op2,
    input  common::op_type_t  [DISPATCH_WIDTH-1:0]                 dispatch_op2_type,
    input  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0]    dispatch_phys_rd,
    output logic                                                   full,
    input  logic              [WB_WIDTH-1:0]                       wb_en,
    input  logic [WB_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0]          wb_tag,
    output logic                                                   issue_valid,
    input  logic                                                   issue_ready,
    output common::alu_cmd_t                                       issue_alu_cmd,
    output logic              [PHYS_REGS_ADDR_WIDTH-1:0]           issue_op1,
    output logic              [31:0]                               issue_op2,
    output common::op_type_t                                       issue_op2_type,
    output logic              [PHYS_REGS_ADDR_WIDTH-1:0]           issue_phys_rd
);

    localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int unsigned CNT_W = $clog2(ENTRIES + 1);
    localparam int unsigned AGE_W = IDX_W + 1;
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    typedef struct packed {
        logic                            valid;
        common::alu_cmd_t                alu_cmd;
        logic [PHYS_REGS_ADDR_WIDTH-1:0] op1;
        logic                            op1_rdy;
        logic [31:0]                     op2;
        logic                            op2_rdy;
        common::op_type_t                op2_type;
        logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_rd;
        logic [AGE_W-1:0]                age;
    } entry_t;

    entry_t                                 ent_q [ENTRIES];
    entry_t                                 ent_d [ENTRIES];
    logic [CNT_W-1:0]                       free_q, free_d;
    logic [ENTRIES-1:0]                     taken;
    logic [DISPATCH_WIDTH-1:0]              alloc_ok;
    logic [DISPATCH_WIDTH-1:0][IDX_W-1:0]   alloc_idx;
    logic [CNT_W-1:0]                       n_disp;
    logic                                   sel_found;
    logic [IDX_W-1:0]                       sel_idx;
    logic [AGE_W-1:0]                       sel_age;
    logic                                   issue_fire;

    function automatic logic tag_hit(
        input logic [PHYS_REGS_ADDR_WIDTH-1:0]                tag,
        input logic [WB_WIDTH-1:0]                            en,
        input logic [WB_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] tags
    );
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < WB_WIDTH; w++) begin
            if (en[w] && (tags[w] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    assign full = (free_q < CNT_W'(DISPATCH_WIDTH));

    // Oldest-ready select; strict '>' keeps the lowest index on equal ages.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        for (int e = 0; e < ENTRIES; e++) begin
            if (ent_q[e].valid && ent_q[e].op1_rdy && ent_q[e].op2_rdy &&
                (!sel_found || (ent_q[e].age > sel_age))) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(e);
                sel_age   = ent_q[e].age;
            end
        end
    end

    assign issue_valid    = sel_found;
    assign issue_fire     = issue_valid && issue_ready;
    assign issue_alu_cmd  = ent_q[sel_idx].alu_cmd;
    assign issue_op1      = ent_q[sel_idx].op1;
    assign issue_op2      = ent_q[sel_idx].op2;
    assign issue_op2_type = ent_q[sel_idx].op2_type;
    assign issue_phys_rd  = ent_q[sel_idx].phys_rd;

    // Slots claim free entries in slot order; an entry issued this cycle is not reusable yet.
    always_comb begin
        for (int e = 0; e < ENTRIES; e++) taken[e] = ent_q[e].valid;
        n_disp    = '0;
        alloc_ok  = '0;
        alloc_idx = '0;
        for (int s = 0; s < DISPATCH_WIDTH; s++) begin
            if (dispatch_en[s] && !full) begin
                for (int e = 0; e < ENTRIES; e++) begin
                    if (!alloc_ok[s] && !taken[e]) begin
                        alloc_ok[s]  = 1'b1;
                        alloc_idx[s] = IDX_W'(e);
                        taken[e]     = 1'b1;
                    end
                end
                if (alloc_ok[s]) n_disp = n_disp + 1'b1;
            end
        end
    end

    always_comb begin
        for (int e = 0; e < ENTRIES; e++) begin
            ent_d[e] = ent_q[e];
            if (ent_q[e].valid) begin
                if (ent_q[e].age != AGE_MAX) ent_d[e].age = ent_q[e].age + 1'b1;
                if (tag_hit(ent_q[e].op1, wb_en, wb_tag)) ent_d[e].op1_rdy = 1'b1;
                if ((ent_q[e].op2_type == common::OpReg) &&
                    tag_hit(ent_q[e].op2[PHYS_REGS_ADDR_WIDTH-1:0], wb_en, wb_tag)) begin
                    ent_d[e].op2_rdy = 1'b1;
                end
            end
        end
        if (issue_fire) ent_d[sel_idx].valid = 1'b0;
        for (int s = 0; s < DISPATCH_WIDTH; s++) begin
            if (alloc_ok[s]) begin
                ent_d[alloc_idx[s]].valid    = 1'b1;
                ent_d[alloc_idx[s]].alu_cmd  = dispatch_alu_cmd[s];
                ent_d[alloc_idx[s]].op1      = dispatch_op1[s];
                ent_d[alloc_idx[s]].op1_rdy  = dispatch_op1_valid[s] ||
                                               tag_hit(dispatch_op1[s], wb_en, wb_tag);
                ent_d[alloc_idx[s]].op2      = dispatch_op2[s];
                ent_d[alloc_idx[s]].op2_rdy  = (dispatch_op2_type[s] == common::OpImm) ||
                    dispatch_op2_valid[s] ||
                    tag_hit(dispatch_op2[s][PHYS_REGS_ADDR_WIDTH-1:0], wb_en, wb_tag);
                ent_d[alloc_idx[s]].op2_type = dispatch_op2_type[s];
                ent_d[alloc_idx[s]].phys_rd  = dispatch_phys_rd[s];
                ent_d[alloc_idx[s]].age      = '0;
            end
        end
        free_d = free_q - n_disp + CNT_W'(issue_fire);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < ENTRIES; e++) ent_q[e] <= '0;
            free_q <= CNT_W'(ENTRIES);
        end else begin
            for (int e = 0; e < ENTRIES; e++) ent_q[e] <= ent_d[e];
            free_q <= free_d;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: expected issues go into a scoreboard queue at dispatch
// and are popped and compared when the queue presents them.
module tb_issue_queue;

    logic                        clk;
    logic                        rst;
    logic [1:0]                  dispatch_en;
    common::alu_cmd_t [1:0]      dispatch_alu_cmd;
    logic [1:0]                  dispatch_op1_valid;
    logic [1:0]                  dispatch_op2_valid;
    logic [1:0][5:0]             dispatch_op1;
    logic [1:0][31:0]            dispatch_op2;
    common::op_type_t [1:0]      dispatch_op2_type;
    logic [1:0][5:0]             dispatch_phys_rd;
    logic                        full;
    logic [1:0]                  wb_en;
    logic [1:0][5:0]             wb_tag;
    logic                        issue_valid;
    logic                        issue_ready;
    common::alu_cmd_t            issue_alu_cmd;
    logic [5:0]                  issue_op1;
    logic [31:0]                 issue_op2;
    common::op_type_t            issue_op2_type;
    logic [5:0]                  issue_phys_rd;

    typedef struct {
        common::alu_cmd_t cmd;
        logic [5:0]       op1;
        logic [31:0]      op2;
        common::op_type_t typ;
        logic [5:0]       rd;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_err;

    issue_queue #(
        .DISPATCH_WIDTH      (2),
        .ENTRIES             (8),
        .PHYS_REGS_ADDR_WIDTH(6),
        .WB_WIDTH            (2)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .dispatch_en       (dispatch_en),
        .dispatch_alu_cmd  (dispatch_alu_cmd),
        .dispatch_op1_valid(dispatch_op1_valid),
        .dispatch_op2_valid(dispatch_op2_valid),
        .dispatch_op1      (dispatch_op1),
        .dispatch_op2      (dispatch_op2),
        .dispatch_op2_type (dispatch_op2_type),
        .dispatch_phys_rd  (dispatch_phys_rd),
        .full              (full),
        .wb_en             (wb_en),
        .wb_tag            (wb_tag),
        .issue_valid       (issue_valid),
        .issue_ready       (issue_ready),
        .issue_alu_cmd     (issue_alu_cmd),
        .issue_op1         (issue_op1),
        .issue_op2         (issue_op2),
        .issue_op2_type    (issue_op2_type),
        .issue_phys_rd     (issue_phys_rd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        dispatch_en        = '0;
        dispatch_op1_valid = '0;
        dispatch_op2_valid = '0;
        dispatch_op1       = '0;
        dispatch_op2       = '0;
        dispatch_phys_rd   = '0;
        wb_en              = '0;
        wb_tag             = '0;
        for (int i = 0; i < 2; i++) begin
            dispatch_alu_cmd[i]  = common::AluAdd;
            dispatch_op2_type[i] = common::OpImm;
        end
    endtask

    task automatic slot(input int s, input common::alu_cmd_t cmd, input logic [5:0] op1,
                        input logic op1v, input logic [31:0] op2, input logic op2v,
                        input common::op_type_t typ, input logic [5:0] rd);
        dispatch_en[s]        = 1'b1;
        dispatch_alu_cmd[s]   = cmd;
        dispatch_op1[s]       = op1;
        dispatch_op1_valid[s] = op1v;
        dispatch_op2[s]       = op2;
        dispatch_op2_valid[s] = op2v;
        dispatch_op2_type[s]  = typ;
        dispatch_phys_rd[s]   = rd;
    endtask

    task automatic push(input common::alu_cmd_t cmd, input logic [5:0] op1,
                        input logic [31:0] op2, input common::op_type_t typ,
                        input logic [5:0] rd);
        exp_t e;
        e.cmd = cmd;
        e.op1 = op1;
        e.op2 = op2;
        e.typ = typ;
        e.rd  = rd;
        exp_q.push_back(e);
    endtask

    // Compare the presented payload with the scoreboard head, then complete the handshake.
    task automatic expect_issue(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s: scoreboard empty, observed issue_valid %0b", tag, issue_valid);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_valid"}, 64'(issue_valid), 64'd1);
            chk({tag, "_cmd"}, 64'(issue_alu_cmd), 64'(e.cmd));
            chk({tag, "_op1"}, 64'(issue_op1), 64'(e.op1));
            chk({tag, "_op2"}, 64'(issue_op2), 64'(e.op2));
            chk({tag, "_type"}, 64'(issue_op2_type), 64'(e.typ));
            chk({tag, "_rd"}, 64'(issue_phys_rd), 64'(e.rd));
        end
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rst         = 1'b0;
        issue_ready = 1'b0;
        clear_in();
        #2 rst = 1'b1;
        #1;
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_issue_valid", 64'(issue_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Both operands ready, immediate op2 with op2_valid low.
        slot(0, common::AluAdd, 6'd5, 1'b1, 32'h10, 1'b0, common::OpImm, 6'd1);
        slot(1, common::AluSub, 6'd5, 1'b1, 32'h10, 1'b0, common::OpImm, 6'd2);
        push(common::AluAdd, 6'd5, 32'h10, common::OpImm, 6'd1);
        push(common::AluSub, 6'd5, 32'h10, common::OpImm, 6'd2);
        chk("pre_disp_valid", 64'(issue_valid), 64'd0);
        tick();
        clear_in();
        expect_issue("imm_a");
        expect_issue("imm_b");
        chk("imm_empty", 64'(issue_valid), 64'd0);

        // op1 woken by a later broadcast; an unrelated tag must not wake it.
        slot(0, common::AluAnd, 6'd7, 1'b0, 32'h22, 1'b0, common::OpImm, 6'd3);
        push(common::AluAnd, 6'd7, 32'h22, common::OpImm, 6'd3);
        tick();
        clear_in();
        chk("wait_c1", 64'(issue_valid), 64'd0);
        wb_en     = 2'b01;
        wb_tag[0] = 6'd8;
        tick();
        clear_in();
        chk("wait_c2", 64'(issue_valid), 64'd0);
        wb_en     = 2'b01;
        wb_tag[0] = 6'd7;
        chk("wake_cycle_valid", 64'(issue_valid), 64'd0);
        tick();
        clear_in();
        expect_issue("wake_op1");
        chk("wake_empty", 64'(issue_valid), 64'd0);

        // Same-cycle wakeup on dispatch; register op2 woken later through port 1.
        wb_en     = 2'b01;
        wb_tag[0] = 6'd9;
        slot(0, common::AluOr, 6'd9, 1'b0, 32'h0c, 1'b1, common::OpReg, 6'd4);
        slot(1, common::AluXor, 6'd11, 1'b1, 32'h14, 1'b0, common::OpReg, 6'd5);
        push(common::AluOr, 6'd9, 32'h0c, common::OpReg, 6'd4);
        tick();
        clear_in();
        expect_issue("same_cycle_wake");
        chk("op2_wait", 64'(issue_valid), 64'd0);
        wb_tag[1] = 6'd20;
        tick();
        clear_in();
        chk("op2_disabled_wb", 64'(issue_valid), 64'd0);
        wb_en     = 2'b10;
        wb_tag[1] = 6'd20;
        push(common::AluXor, 6'd11, 32'h14, common::OpReg, 6'd5);
        tick();
        clear_in();
        expect_issue("op2_wake");
        chk("op2_empty", 64'(issue_valid), 64'd0);

        // Age select: older entry at index 3 beats a younger one refilled at index 0.
        slot(0, common::AluAdd, 6'd1, 1'b1, 32'h100, 1'b0, common::OpImm, 6'd10);
        slot(1, common::AluAdd, 6'd40, 1'b0, 32'h101, 1'b0, common::OpImm, 6'd11);
        tick();
        clear_in();
        slot(0, common::AluSub, 6'd40, 1'b0, 32'h102, 1'b0, common::OpImm, 6'd12);
        slot(1, common::AluSub, 6'd2, 1'b1, 32'h103, 1'b0, common::OpImm, 6'd13);
        push(common::AluAdd, 6'd1, 32'h100, common::OpImm, 6'd10);
        tick();
        clear_in();
        expect_issue("age_first");
        slot(0, common::AluAnd, 6'd3, 1'b1, 32'h104, 1'b0, common::OpImm, 6'd14);
        tick();
        clear_in();
        push(common::AluSub, 6'd2, 32'h103, common::OpImm, 6'd13);
        push(common::AluAnd, 6'd3, 32'h104, common::OpImm, 6'd14);
        expect_issue("age_old_idx3");
        expect_issue("age_young_idx0");
        wb_en     = 2'b01;
        wb_tag[0] = 6'd40;
        push(common::AluAdd, 6'd40, 32'h101, common::OpImm, 6'd11);
        push(common::AluSub, 6'd40, 32'h102, common::OpImm, 6'd12);
        tick();
        clear_in();
        expect_issue("age_wake_a");
        expect_issue("age_wake_b");
        chk("age_empty", 64'(issue_valid), 64'd0);

        // Fill to 7 of 8 with no issue, check full and dropped dispatch.
        for (int r = 0; r < 3; r++) begin
            slot(0, common::AluAdd, 6'(r), 1'b1, 32'(r), 1'b0, common::OpImm, 6'(20 + 2 * r));
            slot(1, common::AluAdd, 6'(r), 1'b1, 32'(r), 1'b0, common::OpImm, 6'(21 + 2 * r));
            push(common::AluAdd, 6'(r), 32'(r), common::OpImm, 6'(20 + 2 * r));
            push(common::AluAdd, 6'(r), 32'(r), common::OpImm, 6'(21 + 2 * r));
            tick();
            clear_in();
        end
        chk("fill6_full", 64'(full), 64'd0);
        slot(0, common::AluAdd, 6'd3, 1'b1, 32'd3, 1'b0, common::OpImm, 6'd26);
        push(common::AluAdd, 6'd3, 32'd3, common::OpImm, 6'd26);
        tick();
        clear_in();
        chk("fill7_full", 64'(full), 64'd1);
        slot(0, common::AluOr, 6'd4, 1'b1, 32'd4, 1'b0, common::OpImm, 6'd60);
        slot(1, common::AluOr, 6'd4, 1'b1, 32'd4, 1'b0, common::OpImm, 6'd61);
        tick();
        clear_in();
        chk("drop_full", 64'(full), 64'd1);
        slot(0, common::AluOr, 6'd4, 1'b1, 32'd4, 1'b0, common::OpImm, 6'd62);
        chk("issue_cycle_full", 64'(full), 64'd1);
        expect_issue("fill_first");
        clear_in();
        chk("after_issue_full", 64'(full), 64'd0);
        for (int i = 0; i < 6; i++) expect_issue("fill_drain");
        chk("fill_drain_empty", 64'(issue_valid), 64'd0);
        chk("fill_drain_full", 64'(full), 64'd0);

        // Reset with four ready entries and issue_ready high: nothing may issue.
        for (int r = 0; r < 2; r++) begin
            slot(0, common::AluSll, 6'd1, 1'b1, 32'd7, 1'b0, common::OpImm, 6'(30 + 2 * r));
            slot(1, common::AluSll, 6'd1, 1'b1, 32'd7, 1'b0, common::OpImm, 6'(31 + 2 * r));
            tick();
            clear_in();
        end
        chk("pre_rst_valid", 64'(issue_valid), 64'd1);
        issue_ready = 1'b1;
        rst         = 1'b1;
        #1;
        chk("rst_mid_valid", 64'(issue_valid), 64'd0);
        chk("rst_mid_full", 64'(full), 64'd0);
        tick();
        rst         = 1'b0;
        issue_ready = 1'b0;
        tick();
        chk("post_rst_valid", 64'(issue_valid), 64'd0);
        chk("post_rst_full", 64'(full), 64'd0);
        slot(0, common::AluSlt, 6'd2, 1'b1, 32'h55, 1'b0, common::OpImm, 6'd40);
        push(common::AluSlt, 6'd2, 32'h55, common::OpImm, 6'd40);
        tick();
        clear_in();
        expect_issue("post_rst_issue");
        chk("post_rst_empty", 64'(issue_valid), 64'd0);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
